// File: rtl/mesh_term_injector.sv
// Mesh terminal injector: validates a destination, builds a router packet and
// queues it in a first-word-fall-through buffer facing the router terminal port.
module mesh_term_injector #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMNS    = 4,
  parameter int unsigned PCKG_SZ    = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  BDCST      = 8'hFF,
  parameter int unsigned TERM_ROW   = 0,
  parameter int unsigned TERM_COL   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_row,
  input  logic [3:0]                    in_col,
  input  logic                          in_bcst,
  input  logic                          in_mode,
  input  logic [PCKG_SZ-18:0]           in_payload,
  input  logic                          flush,
  output logic [PCKG_SZ-1:0]            data_out_i_in,
  output logic                          pndng_i_in,
  input  logic                          popin,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [15:0]                   sent_cnt,
  output logic [15:0]                   drop_cnt,
  output logic                          pop_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    ROW_MAX   = 4'(ROWS);
  localparam logic [3:0]    COL_MAX   = 4'(COLUMNS);
  localparam logic [3:0]    ROW_LAST  = 4'(ROWS + 1);
  localparam logic [3:0]    COL_LAST  = 4'(COLUMNS + 1);
  localparam logic [3:0]    SELF_ROW  = 4'(TERM_ROW);
  localparam logic [3:0]    SELF_COL  = 4'(TERM_COL);

  logic [PCKG_SZ-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               alive;

  logic               row_edge;
  logic               col_edge;
  logic               row_inner;
  logic               col_inner;
  logic               is_self;
  logic               dest_ok;
  logic [7:0]         addr_field;
  logic [PCKG_SZ-1:0] pkt;
  logic               full;
  logic               empty;
  logic               hshake;
  logic               push;
  logic               pop;
  logic               drop_ev;

  // Destination must sit on the outer terminal ring (corners excluded) and not be us
  always_comb begin
    row_edge  = (in_row == 4'd0) || (in_row == ROW_LAST);
    col_edge  = (in_col == 4'd0) || (in_col == COL_LAST);
    row_inner = (in_row >= 4'd1) && (in_row <= ROW_MAX);
    col_inner = (in_col >= 4'd1) && (in_col <= COL_MAX);
    is_self   = (in_row == SELF_ROW) && (in_col == SELF_COL);
    dest_ok   = in_bcst || (((row_edge && col_inner) || (col_edge && row_inner)) && !is_self);
  end

  // Packet: next-jump (zero), {row,col} or broadcast id, mode, payload
  always_comb begin
    addr_field = in_bcst ? BDCST : {in_row, in_col};
    pkt        = {8'h00, addr_field, in_mode, in_payload};
  end

  always_comb begin
    full     = (count == DEPTH_CNT);
    empty    = (count == '0);
    in_ready = alive && !full && !flush;
    hshake   = in_valid && in_ready;
    push     = hshake && dest_ok;
    drop_ev  = hshake && !dest_ok;
    pop      = popin && !empty && !flush;
  end

  always_comb begin
    pndng_i_in    = !empty;
    data_out_i_in = empty ? '0 : mem[rd_ptr];
    occupancy     = count;
  end

  // Storage carries no reset; the empty mask hides stale entries
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pkt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Saturating statistics and sticky underflow flag survive a flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
      pop_err  <= 1'b0;
    end else begin
      if (pop && (sent_cnt != 16'hFFFF)) begin
        sent_cnt <= sent_cnt + 16'd1;
      end
      if (drop_ev && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (popin && empty) begin
        pop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mesh_term_injector.sv
// Randomised scoreboard bench for mesh_term_injector against a queue-based model.
module tb_mesh_term_injector;

  localparam int unsigned ROWS       = 4;
  localparam int unsigned COLUMNS    = 4;
  localparam int unsigned PCKG_SZ    = 32;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned TERM_ROW   = 0;
  localparam int unsigned TERM_COL   = 1;
  localparam int unsigned PW         = PCKG_SZ - 17;
  localparam int unsigned OW         = $clog2(FIFO_DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_row;
  logic [3:0]         in_col;
  logic               in_bcst;
  logic               in_mode;
  logic [PW-1:0]      in_payload;
  logic               flush;
  logic [PCKG_SZ-1:0] data_out_i_in;
  logic               pndng_i_in;
  logic               popin;
  logic [OW-1:0]      occupancy;
  logic [15:0]        sent_cnt;
  logic [15:0]        drop_cnt;
  logic               pop_err;

  always #5 clk = ~clk;

  mesh_term_injector #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .PCKG_SZ(PCKG_SZ), .FIFO_DEPTH(FIFO_DEPTH),
    .BDCST(8'hFF), .TERM_ROW(TERM_ROW), .TERM_COL(TERM_COL)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_col(in_col), .in_bcst(in_bcst), .in_mode(in_mode),
    .in_payload(in_payload), .flush(flush), .data_out_i_in(data_out_i_in),
    .pndng_i_in(pndng_i_in), .popin(popin), .occupancy(occupancy),
    .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .pop_err(pop_err)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [PCKG_SZ-1:0] exp_q[$];
  int unsigned        m_sent = 0;
  int unsigned        m_drop = 0;
  logic               m_err = 1'b0;
  logic               m_alive = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Terminal ring membership, straight from the addressing rule
  function automatic bit ref_legal(input int unsigned r, input int unsigned c);
    bit ring;
    ring = ((r == 0 || r == ROWS + 1) && c >= 1 && c <= COLUMNS) ||
           ((c == 0 || c == COLUMNS + 1) && r >= 1 && r <= ROWS);
    return ring && !(r == TERM_ROW && c == TERM_COL);
  endfunction

  function automatic logic [PCKG_SZ-1:0] ref_pkt(input bit b, input int unsigned r,
                                                 input int unsigned c, input bit m,
                                                 input int unsigned p);
    longint unsigned addr;
    longint unsigned v;
    addr = b ? 64'd255 : 64'(r * 16 + c);
    v = (addr << (PW + 1)) + (64'(m) << PW) + 64'(p);
    return PCKG_SZ'(v);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_alive <= 1'b0;
    else        m_alive <= 1'b1;
  end

  // Monitor + model: compare the visible state, then apply this cycle's events
  always @(negedge clk or negedge reset) begin : monitor
    bit          rdy;
    int unsigned n;
    if (!reset) begin
      exp_q.delete();
      m_sent = 0;
      m_drop = 0;
      m_err  = 1'b0;
    end else begin
      n   = exp_q.size();
      rdy = m_alive && !flush && (n < FIFO_DEPTH);
      check("in_ready", 64'(in_ready), 64'(rdy));
      check("pndng", 64'(pndng_i_in), 64'(n != 0));
      check("occupancy", 64'(occupancy), 64'(n));
      check("sent_cnt", 64'(sent_cnt), 64'(m_sent));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check("pop_err", 64'(pop_err), 64'(m_err));
      if (n != 0) check("head", 64'(data_out_i_in), 64'(exp_q[0]));
      else        check("empty_data", 64'(data_out_i_in), 64'd0);
      if (popin && n == 0) m_err = 1'b1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (popin && n != 0) begin
          void'(exp_q.pop_front());
          if (m_sent < 65535) m_sent++;
        end
        if (in_valid && rdy) begin
          if (in_bcst || ref_legal(32'(in_row), 32'(in_col)))
            exp_q.push_back(ref_pkt(in_bcst, 32'(in_row), 32'(in_col), in_mode, 32'(in_payload)));
          else if (m_drop < 65535)
            m_drop++;
        end
      end
    end
  end

  task automatic drive(input bit v, input int unsigned r, input int unsigned c, input bit b,
                       input bit m, input int unsigned p, input bit pp, input bit fl);
    in_valid   = v;
    in_row     = 4'(r);
    in_col     = 4'(c);
    in_bcst    = b;
    in_mode    = m;
    in_payload = PW'(p);
    popin      = pp;
    flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_legal(input int unsigned p, input bit pp);
    int unsigned r;
    int unsigned c;
    do begin
      r = $urandom_range(0, ROWS + 1);
      c = $urandom_range(0, COLUMNS + 1);
    end while (!ref_legal(r, c));
    drive(1'b1, r, c, 1'b0, 1'($urandom_range(0, 1)), p, pp, 1'b0);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_pndng", 64'(pndng_i_in), 64'd0);
    check("rst_data", 64'(data_out_i_in), 64'd0);
    reset = 1'b1;
    step();
    check("ready_after_rst", 64'(in_ready), 64'd1);

    drive(1'b1, 0, 2, 1'b0, 1'b1, 'h1234, 1'b0, 1'b0);
    step();
    idle();
    check("first_pndng", 64'(pndng_i_in), 64'd1);
    check("first_data", 64'(data_out_i_in), 64'h0000_0000_0002_9234);
    check("first_occ", 64'(occupancy), 64'd1);

    drive(1'b1, 3, 3, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    step();
    idle();
    check("bcst_data", 64'(data_out_i_in), 64'h0000_0000_00FF_0000);
    check("bcst_occ", 64'(occupancy), 64'd1);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    step();
    idle();
    check("bcst_pop_pndng", 64'(pndng_i_in), 64'd0);
    check("bcst_pop_sent", 64'(sent_cnt), 64'd2);

    drive(1'b1, 2, 2, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    step();
    drive(1'b1, 0, 1, 1'b0, 1'b0, 6, 1'b0, 1'b0);
    step();
    idle();
    check("drop_cnt2", 64'(drop_cnt), 64'd2);
    check("drop_occ", 64'(occupancy), 64'd0);

    for (int i = 0; i < 16; i++) begin
      push_legal(32'(i) + 32'h100, 1'b0);
      step();
    end
    idle();
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_occ", 64'(occupancy), 64'd16);
    drive(1'b1, 0, 3, 1'b0, 1'b0, 7, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      step();
    end
    idle();
    check("drain_sent", 64'(sent_cnt), 64'd18);
    check("drain_occ", 64'(occupancy), 64'd0);

    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    step();
    idle();
    check("pop_err_set", 64'(pop_err), 64'd1);
    check("pop_err_occ", 64'(occupancy), 64'd0);

    repeat (3000) begin
      int unsigned r;
      int unsigned c;
      if ($urandom_range(0, 9) < 8) begin
        r = $urandom_range(0, 5);
        c = $urandom_range(0, 5);
      end else begin
        r = $urandom_range(0, 15);
        c = $urandom_range(0, 15);
      end
      drive(1'($urandom_range(0, 9) < 7), r, c, 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)), $urandom_range(0, 32767),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      step();
    end

    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      push_legal(32'(i) + 32'h200, 1'b0);
      step();
    end
    idle();
    check("pre_rst_occ", 64'(occupancy), 64'd5);
    reset = 1'b0;
    #1;
    check("async_pndng", 64'(pndng_i_in), 64'd0);
    check("async_occ", 64'(occupancy), 64'd0);
    check("async_sent", 64'(sent_cnt), 64'd0);
    check("async_drop", 64'(drop_cnt), 64'd0);
    check("async_err", 64'(pop_err), 64'd0);
    check("async_data", 64'(data_out_i_in), 64'd0);
    check("async_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    repeat (4) step();
    check("post_rst_ready", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mesh_term_injector.md
MESH_TERM_INJECTOR -- requirements
Module: mesh_term_injector

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, meaning the number of mesh router rows.
REQ-002 The block SHALL have parameter COLUMNS, default 4, meaning the number of mesh router columns.
REQ-003 The block SHALL have parameter PCKG_SZ, default 32, meaning the packet width in bits (minimum 18).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the injection buffer entries (power of 2, minimum 2).
REQ-005 The block SHALL have parameter BDCST, default 8'hFF, meaning the broadcast ID written into the {row,col} field.
REQ-006 The block SHALL have parameters TERM_ROW and TERM_COL, default 0 and 1, meaning this terminal's own mesh address.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port in_valid, input, 1 bit: the producer offers a packet request.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-011 The block SHALL have ports in_row and in_col, input, 4 bits each: the destination terminal address.
REQ-012 The block SHALL have port in_bcst, input, 1 bit: the request is a broadcast.
REQ-013 The block SHALL have port in_mode, input, 1 bit: the routing mode bit (0 row-first, 1 column-first).
REQ-014 The block SHALL have port in_payload, input, PCKG_SZ-17 bits: the payload.
REQ-015 The block SHALL have port flush, input, 1 bit: a synchronous buffer clear.
REQ-016 The block SHALL have port data_out_i_in, output, PCKG_SZ bits: the head packet toward the router terminal.
REQ-017 The block SHALL have port pndng_i_in, output, 1 bit: a packet is pending at the head.
REQ-018 The block SHALL have port popin, input, 1 bit: the router consumes the head this cycle.
REQ-019 The block SHALL have port occupancy, output, $clog2(FIFO_DEPTH)+1 bits: the stored entry count.
REQ-020 The block SHALL have ports sent_cnt and drop_cnt, output, 16 bits each: the popped-packet and dropped-request counts.
REQ-021 The block SHALL have port pop_err, output, 1 bit: a sticky flag set when popin arrives while the buffer is empty.

Function
REQ-022 Packet format SHALL be: [PCKG_SZ-1:PCKG_SZ-8] next-jump = 8'h00; [PCKG_SZ-9:PCKG_SZ-12] row; [PCKG_SZ-13:PCKG_SZ-16] col; [PCKG_SZ-17] mode; [PCKG_SZ-18:0] payload.
REQ-023 When in_bcst=1, the {row,col} field SHALL equal BDCST, and in_row/in_col SHALL be ignored.
REQ-024 A non-broadcast destination SHALL be legal only if (row∈{0,ROWS+1} and 1≤col≤COLUMNS) or (col∈{0,COLUMNS+1} and 1≤row≤ROWS), and only if it differs from {TERM_ROW,TERM_COL}.
REQ-025 A handshake SHALL occur when in_valid=1 and in_ready=1; in_ready SHALL equal !full, computed from registered occupancy only.
REQ-026 A handshake with a legal destination SHALL write the built packet at the tail; occupancy SHALL increment on the next edge.
REQ-027 A handshake with an illegal destination SHALL NOT write the buffer, and drop_cnt SHALL increment by 1.
REQ-028 The buffer SHALL be first-word-fall-through: pndng_i_in = (occupancy≠0), and data_out_i_in SHALL show the head entry combinationally from storage.
REQ-029 Latency SHALL be one cycle: a packet written into an empty buffer at edge N SHALL raise pndng_i_in after edge N.
REQ-030 popin=1 with pndng_i_in=1 SHALL remove the head at the next edge, and sent_cnt SHALL increment.
REQ-031 popin=1 with pndng_i_in=0 SHALL be ignored for data, and SHALL set pop_err until reset.
REQ-032 A simultaneous push and pop SHALL leave occupancy unchanged and advance both pointers; when occupancy=0 the pushed entry SHALL NOT be popped in the same cycle.
REQ-033 When full, in_ready SHALL be 0, including cycles where popin=1; the slot frees on the following cycle.
REQ-034 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 sent_cnt and drop_cnt SHALL saturate at 16'hFFFF.
REQ-036 flush=1 SHALL zero the pointers and occupancy at the next edge, and SHALL force in_ready=0 in that cycle; a pop in that cycle SHALL NOT count, and counters and pop_err SHALL be retained.

Reset
REQ-037 reset=0 SHALL immediately and asynchronously clear pointers, occupancy, sent_cnt, drop_cnt and pop_err; pndng_i_in SHALL be 0 and data_out_i_in SHALL be all zeros.
REQ-038 in_ready SHALL be 0 while reset=0, and SHALL be 1 from the first edge after reset deasserts.
REQ-039 Reset asserted mid-transfer SHALL discard all buffered packets with no partial pop.

Verification
REQ-040 Reset release, push row=0 col=2 mode=1 payload=15'h1234 -> next cycle pndng_i_in=1, data_out_i_in=32'h0002_9234, occupancy=1.
REQ-041 Push in_bcst=1 payload=0 -> data_out_i_in=32'h00FF_0000; pop -> sent_cnt=1, pndng_i_in=0.
REQ-042 Push row=2 col=2 (interior), then row=0 col=1 (self) -> drop_cnt=2, occupancy=0, pndng_i_in never 1.
REQ-043 Push 16 legal packets with popin=0 -> in_ready=0 and occupancy=16; hold popin=1 for 16 cycles -> in-order output, sent_cnt=16, pointers wrapped.
REQ-044 popin=1 while empty -> pop_err=1 and occupancy stays 0; assert reset=0 for 1 ns with 5 entries stored -> pndng_i_in=0 asynchronously, all counters 0.
